// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: 32-step radix-2 Booth multiply / restoring divide into hi/lo with start/busy/done handshake.
// Divider (DIV, FIX states and div_by_zero) is compiled in only when MULDIV_DIV_EN is defined.
module mul_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
`ifdef MULDIV_DIV_EN
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
  state_t state, state_nx;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q, m;
  logic             q_1;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [WIDTH:0]   m_x, b_sum;
  logic [1:0]       bp;
  assign last  = cnt == CNT_W'(1);
  assign m_x   = {m[WIDTH-1], m};
  assign bp    = {q[0], q_1};
  assign b_sum = (bp == 2'b01) ? acc + m_x : (bp == 2'b10) ? acc - m_x : acc;
`ifdef MULDIV_DIV_EN
  // acc[WIDTH-1:0] holds the partial remainder, q the quotient bits, m the divisor magnitude
  logic [WIDTH-1:0] a_l, a_abs, b_abs, r_sh, r_n;
  logic [WIDTH:0]   trial;
  logic             neg_q, neg_r;
  assign a_abs = a[WIDTH-1] ? -a : a;
  assign b_abs = b[WIDTH-1] ? -b : b;
  assign r_sh  = {acc[WIDTH-2:0], q[WIDTH-1]};
  assign trial = {1'b0, r_sh} - {1'b0, m};
  assign r_n   = trial[WIDTH] ? r_sh : trial[WIDTH-1:0];
  assign busy  = state == MUL || state == DIV || state == FIX;
`else
  logic unused_op;
  assign unused_op = op;
  assign busy      = state == MUL;
`endif
  assign done = state == DONE;
  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
`ifdef MULDIV_DIV_EN
      IDLE: if (start) state_nx = !op ? MUL : (b == '0) ? FIX : DIV;
      MUL:  if (last) state_nx = DONE;
      DIV:  if (last) state_nx = FIX;
      FIX:  state_nx = DONE;
`else
      IDLE: if (start) state_nx = MUL;
      MUL:  if (last) state_nx = DONE;
`endif
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      acc         <= '0;
      q           <= '0;
      q_1         <= 1'b0;
      m           <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      a_l         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          acc         <= '0;
          q_1         <= 1'b0;
          cnt         <= CNT_W'(WIDTH);
          div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
          m           <= op ? b_abs : a;
          q           <= op ? a_abs : b;
          a_l         <= a;
          neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r       <= a[WIDTH-1];
`else
          m           <= a;
          q           <= b;
`endif
        end
        MUL: begin
          acc <= {b_sum[WIDTH], b_sum[WIDTH:1]};
          q   <= {b_sum[0], q[WIDTH-1:1]};
          q_1 <= q[0];
          cnt <= cnt - 1'b1;
          // final step writes the shifted result straight into hi/lo as DONE is entered
          if (last) {hi, lo} <= {b_sum[WIDTH:1], b_sum[0], q[WIDTH-1:1]};
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          acc <= {1'b0, r_n};
          q   <= {q[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt - 1'b1;
        end
        FIX: if (m == '0) begin
          lo          <= '1;
          hi          <= a_l;
          div_by_zero <= 1'b1;
        end else begin
          lo <= neg_q ? -q : q;
          hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
`endif
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer: directed vectors for mul_div_sequencer; expectations follow MULDIV_DIV_EN.
module tb_mul_div_sequencer;
  logic        clock = 0, clear = 0, start = 0, op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  int          total = 0, passed = 0, cyc = 0;
  mul_div_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );
  always #5 clock = ~clock;
  task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task go(input logic o, input logic [31:0] x, input logic [31:0] y, input logic keep);
    op = o; a = x; b = y; start = 1;
    @(posedge clock); #1;
    start = keep;
    cyc = 1;
  endtask
  task finish(input string tag, input int lat, input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int bad;
    bad = 0;
    while (!done && cyc < 100) begin
      if (busy !== 1'b1) bad++;
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_busy_before"}, bad, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_dz"}, div_by_zero, edz);
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold"}, {hi, lo}, {eh, el});
  endtask
  initial begin
    int bad;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_dz", div_by_zero, 0);
    clear = 1;
    @(posedge clock); #1;
    go(0, 32'd7, -32'sd3, 0);
    finish("mul_7x-3", 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    go(0, 32'h80000000, 32'h80000000, 0);
    finish("mul_min2", 33, 32'h40000000, 32'h00000000, 0);
    go(0, 32'h7FFFFFFF, 32'hFFFFFFFF, 0);
    finish("mul_max_neg1", 33, 32'hFFFFFFFF, 32'h80000001, 0);
`ifdef MULDIV_DIV_EN
    go(1, -32'sd17, 32'd5, 0);
    finish("div_-17_5", 34, 32'hFFFFFFFE, 32'hFFFFFFFD, 0);
    go(1, 32'h80000000, 32'hFFFFFFFF, 0);
    finish("div_min_neg1", 34, 32'h00000000, 32'h80000000, 0);
    go(1, 32'd42, 32'd0, 0);
    finish("div_by0", 2, 32'd42, 32'hFFFFFFFF, 1);
`else
    go(1, -32'sd17, 32'd5, 0);
    finish("op1_as_mul_a", 33, 32'hFFFFFFFF, 32'hFFFFFFAB, 0);
    go(1, 32'h80000000, 32'hFFFFFFFF, 0);
    finish("op1_as_mul_b", 33, 32'h00000000, 32'h80000000, 0);
    go(1, 32'd42, 32'd0, 0);
    finish("op1_as_mul_c", 33, 32'h00000000, 32'h00000000, 0);
`endif
    go(0, 32'd2, 32'd3, 0);
    finish("mul_2x3", 33, 32'h0, 32'd6, 0);
    go(0, 32'd3, 32'd4, 1);
    a = 32'd5; b = 32'd6;
    finish("hold1", 33, 32'h0, 32'd12, 0);
    check("hold_idle_busy", busy, 0);
    @(posedge clock); #1;
    check("hold_accept_busy", busy, 1);
    start = 0;
    cyc = 1;
    finish("hold2", 33, 32'h0, 32'd30, 0);
    go(1, 32'd100, 32'd7, 0);
    repeat (9) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("abort_busy_mid", busy, 1);
    #2 clear = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hilo", {hi, lo}, 64'h0);
    check("abort_dz", div_by_zero, 0);
    bad = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_no_done", bad, 0);
    clear = 1;
    @(posedge clock); #1;
    go(0, -32'sd6, 32'd9, 0);
    finish("post_abort_mul", 33, 32'hFFFFFFFF, 32'hFFFFFFCA, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
